// File: rtl/csr_regfile.sv
// csr_regfile: control/status registers with exception entry/return bookkeeping,
// interrupt pending detection and a down-counting timer.
module csr_regfile #(
    parameter logic [31:0] TID_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_rd_num,
    output logic [31:0] csr_rd_value,
    input  logic        csr_we,
    input  logic [13:0] csr_wr_num,
    input  logic [31:0] csr_wr_mask,
    input  logic [31:0] csr_wr_value,
    input  logic [5:0]  wb_exc,
    input  logic        ertn_flush,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_fault_vaddr,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);
    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_SAVE1  = 14'h31;
    localparam logic [13:0] CSR_SAVE2  = 14'h32;
    localparam logic [13:0] CSR_SAVE3  = 14'h33;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    // wb_exc bit positions: {adef, ale, brk, ine, int, sys}
    localparam int EXC_SYS  = 0;
    localparam int EXC_INT  = 1;
    localparam int EXC_INE  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_ALE  = 4;
    localparam int EXC_ADEF = 5;

    logic [1:0]       crmd_plv_q, crmd_plv_d;
    logic             crmd_ie_q, crmd_ie_d;
    logic             crmd_da_q, crmd_da_d;
    logic [1:0]       prmd_pplv_q, prmd_pplv_d;
    logic             prmd_pie_q, prmd_pie_d;
    logic [12:0]      ecfg_lie_q, ecfg_lie_d;
    logic [12:0]      estat_is_q, estat_is_d;
    logic [5:0]       estat_ecode_q, estat_ecode_d;
    logic [31:0]      era_q, era_d;
    logic [31:0]      badv_q, badv_d;
    logic [25:0]      eentry_va_q, eentry_va_d;
    logic [3:0][31:0] save_q, save_d;
    logic [31:0]      tid_q, tid_d;
    logic             tcfg_en_q, tcfg_en_d;
    logic             tcfg_periodic_q, tcfg_periodic_d;
    logic [29:0]      tcfg_initval_q, tcfg_initval_d;
    logic [31:0]      tval_q, tval_d;

    logic [31:0] crmd_img, prmd_img, ecfg_img, estat_img, eentry_img, tcfg_img;
    logic        exc_valid, ertn_valid, wr_valid, timer_fire;
    logic [31:0] wr_old, wr_new;
    logic        ticlr_clr, tcfg_wr;
    logic [5:0]  exc_code;

    assign crmd_img   = {28'h0, crmd_da_q, crmd_ie_q, crmd_plv_q};
    assign prmd_img   = {29'h0, prmd_pie_q, prmd_pplv_q};
    assign ecfg_img   = {19'h0, ecfg_lie_q};
    assign estat_img  = {10'h0, estat_ecode_q, 3'h0, estat_is_q};
    assign eentry_img = {eentry_va_q, 6'h0};
    assign tcfg_img   = {tcfg_initval_q, tcfg_periodic_q, tcfg_en_q};

    function automatic logic [31:0] read_csr(input logic [13:0] num);
        logic [31:0] val;
        case (num)
            CSR_CRMD:   val = crmd_img;
            CSR_PRMD:   val = prmd_img;
            CSR_ECFG:   val = ecfg_img;
            CSR_ESTAT:  val = estat_img;
            CSR_ERA:    val = era_q;
            CSR_BADV:   val = badv_q;
            CSR_EENTRY: val = eentry_img;
            CSR_SAVE0:  val = save_q[0];
            CSR_SAVE1:  val = save_q[1];
            CSR_SAVE2:  val = save_q[2];
            CSR_SAVE3:  val = save_q[3];
            CSR_TID:    val = tid_q;
            CSR_TCFG:   val = tcfg_img;
            CSR_TVAL:   val = tval_q;
            default:    val = 32'h0;
        endcase
        return val;
    endfunction

    // Exceptions win over ertn, and either one swallows a same-cycle CSR write.
    assign exc_valid  = |wb_exc;
    assign ertn_valid = ertn_flush & ~exc_valid;
    assign wr_valid   = csr_we & ~exc_valid & ~ertn_flush;
    assign timer_fire = tcfg_en_q & (tval_q == 32'h0);

    assign wr_old = read_csr(csr_wr_num);
    assign wr_new = (wr_old & ~csr_wr_mask) | (csr_wr_value & csr_wr_mask);

    always_comb begin
        if (wb_exc[EXC_INT])       exc_code = 6'h00;
        else if (wb_exc[EXC_ADEF]) exc_code = 6'h08;
        else if (wb_exc[EXC_INE])  exc_code = 6'h0D;
        else if (wb_exc[EXC_SYS])  exc_code = 6'h0B;
        else if (wb_exc[EXC_BRK])  exc_code = 6'h0C;
        else                       exc_code = 6'h09;
    end

    always_comb begin
        crmd_plv_d      = crmd_plv_q;
        crmd_ie_d       = crmd_ie_q;
        crmd_da_d       = crmd_da_q;
        prmd_pplv_d     = prmd_pplv_q;
        prmd_pie_d      = prmd_pie_q;
        ecfg_lie_d      = ecfg_lie_q;
        estat_is_d      = estat_is_q;
        estat_ecode_d   = estat_ecode_q;
        era_d           = era_q;
        badv_d          = badv_q;
        eentry_va_d     = eentry_va_q;
        save_d          = save_q;
        tid_d           = tid_q;
        tcfg_en_d       = tcfg_en_q;
        tcfg_periodic_d = tcfg_periodic_q;
        tcfg_initval_d  = tcfg_initval_q;
        tval_d          = tval_q;
        ticlr_clr       = 1'b0;
        tcfg_wr         = 1'b0;

        if (exc_valid) begin
            prmd_pplv_d   = crmd_plv_q;
            prmd_pie_d    = crmd_ie_q;
            crmd_plv_d    = 2'd0;
            crmd_ie_d     = 1'b0;
            era_d         = wb_pc;
            estat_ecode_d = exc_code;
            if (wb_exc[EXC_ADEF])
                badv_d = wb_pc;
            else if (wb_exc[EXC_ALE])
                badv_d = wb_fault_vaddr;
        end else if (ertn_valid) begin
            crmd_plv_d = prmd_pplv_q;
            crmd_ie_d  = prmd_pie_q;
        end else if (wr_valid) begin
            case (csr_wr_num)
                CSR_CRMD: begin
                    crmd_plv_d = wr_new[1:0];
                    crmd_ie_d  = wr_new[2];
                    crmd_da_d  = wr_new[3];
                end
                CSR_PRMD: begin
                    prmd_pplv_d = wr_new[1:0];
                    prmd_pie_d  = wr_new[2];
                end
                CSR_ECFG:   ecfg_lie_d = wr_new[12:0] & 13'h1BFF;
                CSR_ESTAT:  estat_is_d[1:0] = wr_new[1:0];
                CSR_ERA:    era_d = wr_new;
                CSR_BADV:   badv_d = wr_new;
                CSR_EENTRY: eentry_va_d = wr_new[31:6];
                CSR_SAVE0:  save_d[0] = wr_new;
                CSR_SAVE1:  save_d[1] = wr_new;
                CSR_SAVE2:  save_d[2] = wr_new;
                CSR_SAVE3:  save_d[3] = wr_new;
                CSR_TID:    tid_d = wr_new;
                CSR_TCFG: begin
                    tcfg_en_d       = wr_new[0];
                    tcfg_periodic_d = wr_new[1];
                    tcfg_initval_d  = wr_new[31:2];
                    tcfg_wr         = 1'b1;
                end
                CSR_TICLR:  ticlr_clr = wr_new[0];
                default: ;
            endcase
        end

        // Hardware-owned IS bits; a timer expiry beats a same-cycle TICLR clear.
        estat_is_d[9:2] = hw_int_in;
        estat_is_d[10]  = 1'b0;
        estat_is_d[12]  = ipi_int_in;
        if (timer_fire)
            estat_is_d[11] = 1'b1;
        else if (ticlr_clr)
            estat_is_d[11] = 1'b0;

        if (tcfg_wr)
            tval_d = {wr_new[31:2], 2'b00};
        else if (tcfg_en_q && tval_q != 32'hFFFF_FFFF) begin
            if (tval_q == 32'h0 && tcfg_periodic_q)
                tval_d = {tcfg_initval_q, 2'b00};
            else
                tval_d = tval_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd_plv_q      <= 2'd0;
            crmd_ie_q       <= 1'b0;
            crmd_da_q       <= 1'b1;
            prmd_pplv_q     <= 2'd0;
            prmd_pie_q      <= 1'b0;
            ecfg_lie_q      <= 13'h0;
            estat_is_q      <= 13'h0;
            estat_ecode_q   <= 6'h0;
            era_q           <= 32'h0;
            badv_q          <= 32'h0;
            eentry_va_q     <= 26'h0;
            save_q          <= '0;
            tid_q           <= TID_RESET;
            tcfg_en_q       <= 1'b0;
            tcfg_periodic_q <= 1'b0;
            tcfg_initval_q  <= 30'h0;
            tval_q          <= 32'hFFFF_FFFF;
        end else begin
            crmd_plv_q      <= crmd_plv_d;
            crmd_ie_q       <= crmd_ie_d;
            crmd_da_q       <= crmd_da_d;
            prmd_pplv_q     <= prmd_pplv_d;
            prmd_pie_q      <= prmd_pie_d;
            ecfg_lie_q      <= ecfg_lie_d;
            estat_is_q      <= estat_is_d;
            estat_ecode_q   <= estat_ecode_d;
            era_q           <= era_d;
            badv_q          <= badv_d;
            eentry_va_q     <= eentry_va_d;
            save_q          <= save_d;
            tid_q           <= tid_d;
            tcfg_en_q       <= tcfg_en_d;
            tcfg_periodic_q <= tcfg_periodic_d;
            tcfg_initval_q  <= tcfg_initval_d;
            tval_q          <= tval_d;
        end
    end

    assign csr_rd_value = read_csr(csr_rd_num);
    assign ex_entry     = eentry_img;
    assign ertn_entry   = era_q;
    assign has_int      = crmd_ie_q & |(estat_is_q & ecfg_lie_q);

endmodule

// File: tb/tb_csr_regfile.sv
// Testbench for csr_regfile: directed scenarios plus randomized traffic checked
// against a CSR-image reference model.
module tb_csr_regfile;
    localparam logic [31:0] TID_INIT = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_rd_num;
    logic [31:0] csr_rd_value;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic [5:0]  wb_exc;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [31:0] wb_fault_vaddr;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        has_int;

    csr_regfile #(.TID_RESET(TID_INIT)) dut (
        .clk(clk), .resetn(resetn),
        .csr_rd_num(csr_rd_num), .csr_rd_value(csr_rd_value),
        .csr_we(csr_we), .csr_wr_num(csr_wr_num),
        .csr_wr_mask(csr_wr_mask), .csr_wr_value(csr_wr_value),
        .wb_exc(wb_exc), .ertn_flush(ertn_flush),
        .wb_pc(wb_pc), .wb_fault_vaddr(wb_fault_vaddr),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
    );

    always #5 clk = ~clk;

    logic        sResetn, sWe, sErtn, sIpi;
    logic [13:0] sWnum, sRd;
    logic [31:0] sWmask, sWval, sPc, sVaddr;
    logic [5:0]  sExc;
    logic [7:0]  sHw;

    logic [31:0] mCrmd, mPrmd, mEcfg, mEstat, mEra, mBadv, mEentry, mTid, mTcfg, mTval;
    logic [31:0] mSave [4];

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] writableMask(input logic [13:0] num);
        case (num)
            14'h00: return 32'h0000_000F;
            14'h01: return 32'h0000_0007;
            14'h04: return 32'h0000_1BFF;
            14'h05: return 32'h0000_0003;
            14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return 32'hFFFF_FFFF;
            14'h0C: return 32'hFFFF_FFC0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [13:0] num);
        case (num)
            14'h00: return mCrmd;
            14'h01: return mPrmd;
            14'h04: return mEcfg;
            14'h05: return mEstat;
            14'h06: return mEra;
            14'h07: return mBadv;
            14'h0C: return mEentry;
            14'h30: return mSave[0];
            14'h31: return mSave[1];
            14'h32: return mSave[2];
            14'h33: return mSave[3];
            14'h40: return mTid;
            14'h41: return mTcfg;
            14'h42: return mTval;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelWrite(input logic [13:0] num, input logic [31:0] v);
        case (num)
            14'h00: mCrmd = v;
            14'h01: mPrmd = v;
            14'h04: mEcfg = v;
            14'h05: mEstat = v;
            14'h06: mEra = v;
            14'h07: mBadv = v;
            14'h0C: mEentry = v;
            14'h30: mSave[0] = v;
            14'h31: mSave[1] = v;
            14'h32: mSave[2] = v;
            14'h33: mSave[3] = v;
            14'h40: mTid = v;
            14'h41: mTcfg = v;
            default: ;
        endcase
    endtask

    function automatic logic modelHasInt();
        return mCrmd[2] && ((mEstat[12:0] & mEcfg[12:0]) != 13'h0);
    endfunction

    // Exception cause table in priority order: {wb_exc bit, Ecode}.
    function automatic logic [5:0] exceptionCode(input logic [5:0] exc);
        int bitOrder [6] = '{1, 5, 2, 0, 3, 4};
        logic [5:0] codes [6] = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        for (int k = 0; k < 6; k++)
            if (exc[bitOrder[k]]) return codes[k];
        return 6'h00;
    endfunction

    task automatic modelStep();
        logic [31:0] oldTcfg, oldTval, wm, newv;
        logic        timerFire, ticlrHit, tcfgHit;
        if (!sResetn) begin
            mCrmd = 32'h8; mPrmd = 0; mEcfg = 0; mEstat = 0; mEra = 0; mBadv = 0;
            mEentry = 0; mTcfg = 0; mTval = 32'hFFFF_FFFF; mTid = TID_INIT;
            for (int k = 0; k < 4; k++) mSave[k] = 0;
            return;
        end
        oldTcfg   = mTcfg;
        oldTval   = mTval;
        timerFire = oldTcfg[0] && oldTval == 0;
        ticlrHit  = 0;
        tcfgHit   = 0;
        if (sExc != 0) begin
            mPrmd = {29'd0, mCrmd[2:0]};
            mCrmd = mCrmd & 32'h8;
            mEra  = sPc;
            mEstat[21:16] = exceptionCode(sExc);
            if (sExc[5]) mBadv = sPc;
            else if (sExc[4]) mBadv = sVaddr;
        end else if (sErtn) begin
            mCrmd = (mCrmd & 32'h8) | (mPrmd & 32'h7);
        end else if (sWe) begin
            if (sWnum == 14'h44) begin
                ticlrHit = sWmask[0] & sWval[0];
            end else begin
                wm   = writableMask(sWnum) & sWmask;
                newv = (modelRead(sWnum) & ~wm) | (sWval & wm);
                modelWrite(sWnum, newv);
                tcfgHit = (sWnum == 14'h41);
            end
        end
        mEstat[9:2] = sHw;
        mEstat[12]  = sIpi;
        if (timerFire) mEstat[11] = 1'b1;
        else if (ticlrHit) mEstat[11] = 1'b0;
        if (tcfgHit)
            mTval = {mTcfg[31:2], 2'b00};
        else if (oldTcfg[0] && oldTval != 32'hFFFF_FFFF)
            mTval = (oldTval == 0 && oldTcfg[1]) ? {oldTcfg[31:2], 2'b00} : oldTval - 1;
    endtask

    task automatic clearStim();
        sResetn = 1; sWe = 0; sWnum = 0; sWmask = 0; sWval = 0; sExc = 0;
        sErtn = 0; sPc = 0; sVaddr = 0; sHw = 0; sIpi = 0; sRd = 0;
    endtask

    task automatic applyStimulus();
        resetn = sResetn; csr_we = sWe; csr_wr_num = sWnum; csr_wr_mask = sWmask;
        csr_wr_value = sWval; wb_exc = sExc; ertn_flush = sErtn; wb_pc = sPc;
        wb_fault_vaddr = sVaddr; hw_int_in = sHw; ipi_int_in = sIpi; csr_rd_num = sRd;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("rd_value", csr_rd_value, modelRead(sRd));
        checkOutput("has_int", {31'd0, has_int}, {31'd0, modelHasInt()});
        checkOutput("ex_entry", ex_entry, mEentry);
        checkOutput("ertn_entry", ertn_entry, mEra);
    endtask

    task automatic idle(input logic [13:0] rd);
        clearStim(); sRd = rd; applyStimulus();
    endtask

    task automatic csrWrite(input logic [13:0] num, input logic [31:0] mask,
                            input logic [31:0] val, input logic [13:0] rd);
        clearStim(); sWe = 1; sWnum = num; sWmask = mask; sWval = val; sRd = rd;
        applyStimulus();
    endtask

    task automatic doReset(input logic [13:0] rd);
        clearStim(); sResetn = 0; sRd = rd; applyStimulus();
    endtask

    function automatic logic [13:0] pickNum();
        case ($urandom_range(0, 16))
            0: return 14'h00;  1: return 14'h01;  2: return 14'h04;  3: return 14'h05;
            4: return 14'h06;  5: return 14'h07;  6: return 14'h0C;  7: return 14'h30;
            8: return 14'h31;  9: return 14'h32; 10: return 14'h33; 11: return 14'h40;
            12: return 14'h41; 13: return 14'h42; 14: return 14'h44;
            15: return 14'h02;
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        doReset(14'h00);
        checkOutput("reset_crmd", csr_rd_value, 32'h0000_0008);
        checkOutput("reset_has_int", {31'd0, has_int}, 32'h0);
        checkOutput("reset_ertn_entry", ertn_entry, 32'h0);
        idle(14'h42);
        checkOutput("reset_tval", csr_rd_value, 32'hFFFF_FFFF);
        idle(14'h40);
        checkOutput("reset_tid", csr_rd_value, TID_INIT);

        csrWrite(14'h00, 32'h7, 32'h5, 14'h00);
        checkOutput("crmd_masked_write", csr_rd_value, 32'h0000_000D);
        csrWrite(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h04);
        checkOutput("ecfg_all_ones", csr_rd_value, 32'h0000_1BFF);

        csrWrite(14'h41, 32'hFFFF_FFFF, 32'h0000_0013, 14'h42);
        checkOutput("tval_load", csr_rd_value, 32'd16);
        for (int k = 1; k <= 16; k++) begin
            idle(14'h42);
            checkOutput("tval_count", csr_rd_value, 32'(16 - k));
        end
        idle(14'h05);
        checkOutput("timer_is11_set", csr_rd_value, 32'h0000_0800);
        checkOutput("timer_has_int", {31'd0, has_int}, 32'h1);
        idle(14'h42);
        checkOutput("tval_reloaded", csr_rd_value, 32'd15);
        csrWrite(14'h44, 32'h1, 32'h1, 14'h05);
        checkOutput("ticlr_clear", csr_rd_value, 32'h0);
        csrWrite(14'h41, 32'hFFFF_FFFF, 32'h0, 14'h41);

        csrWrite(14'h00, 32'h7, 32'h7, 14'h00);
        clearStim(); sExc = 6'b000001; sPc = 32'h1C00_0100; sRd = 14'h06;
        applyStimulus();
        checkOutput("sys_era", csr_rd_value, 32'h1C00_0100);
        idle(14'h05);
        checkOutput("sys_ecode", csr_rd_value, 32'h000B_0000);
        idle(14'h01);
        checkOutput("sys_prmd", csr_rd_value, 32'h0000_0007);
        idle(14'h00);
        checkOutput("sys_crmd", csr_rd_value, 32'h0000_0008);

        clearStim(); sErtn = 1; sRd = 14'h00;
        applyStimulus();
        checkOutput("ertn_crmd", csr_rd_value, 32'h0000_000F);
        checkOutput("ertn_entry", ertn_entry, 32'h1C00_0100);

        clearStim(); sExc = 6'b010000; sVaddr = 32'h8000_0003; sPc = 32'h1C00_0200;
        sWe = 1; sWnum = 14'h30; sWmask = 32'hFFFF_FFFF; sWval = 32'hDEAD_BEEF; sRd = 14'h30;
        applyStimulus();
        checkOutput("ale_save0_kept", csr_rd_value, 32'h0);
        idle(14'h07);
        checkOutput("ale_badv", csr_rd_value, 32'h8000_0003);
        idle(14'h05);
        checkOutput("ale_ecode", csr_rd_value, 32'h0009_0000);

        doReset(14'h00);
        csrWrite(14'h04, 32'h4, 32'h4, 14'h04);
        csrWrite(14'h00, 32'h4, 32'h4, 14'h00);
        checkOutput("int_idle", {31'd0, has_int}, 32'h0);
        clearStim(); sHw = 8'h01; sRd = 14'h05;
        applyStimulus();
        checkOutput("int_pending", {31'd0, has_int}, 32'h1);
        clearStim(); sResetn = 0; sHw = 8'h01;
        applyStimulus();
        checkOutput("int_after_reset", {31'd0, has_int}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            clearStim();
            sHw  = 8'($urandom);
            sIpi = 1'($urandom);
            sRd  = pickNum();
            r = $urandom_range(0, 99);
            if (r < 2) begin
                sResetn = 0;
            end else if (r < 9) begin
                sExc = 6'($urandom_range(1, 63));
                if (sExc[5]) sExc[4] = 1'b0;
                sPc = $urandom; sVaddr = $urandom;
            end else if (r < 14) begin
                sErtn = 1;
            end
            if ($urandom_range(0, 1) == 1) begin
                sWe    = 1;
                sWnum  = pickNum();
                sWmask = ($urandom_range(0, 2) == 0) ? $urandom : 32'hFFFF_FFFF;
                sWval  = $urandom;
                if (sWnum == 14'h41)
                    sWval = 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            end
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter TID_RESET, default 32'h0000_0000, reset value of TID.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have ports: resetn  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: csr_rd_num  in  14  read CSR number; csr_rd_value  out  32  combinational read data.
REQ-005 SHALL have ports: csr_we  in  1; csr_wr_num  in  14; csr_wr_mask  in  32; csr_wr_value  in  32 (WB-stage write port).
REQ-006 SHALL have ports: wb_exc  in  6  {adef, ale, brk, ine, int, sys}; ertn_flush  in  1; wb_pc  in  32; wb_fault_vaddr  in  32.
REQ-007 SHALL have ports: hw_int_in  in  8; ipi_int_in  in  1 (level-sampled interrupt lines).
REQ-008 SHALL have ports: ex_entry  out  32  = EENTRY; ertn_entry  out  32  = ERA; has_int  out  1  pending enabled interrupt.

Function
REQ-009 SHALL implement CSRs: CRMD 0x00, PRMD 0x01, ECFG 0x04, ESTAT 0x05, ERA 0x06, BADV 0x07, EENTRY 0x0C, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44; unimplemented numbers read 0, writes ignored.
REQ-010 SHALL apply writes as new = (old & ~mask) | (value & mask), restricted to writable bits, one cycle after csr_we sampled high.
REQ-011 SHALL define fields: CRMD PLV[1:0], IE[2], DA[3]; PRMD PPLV[1:0], PIE[2]; ECFG LIE[12:0] with bit 10 read-only 0; ESTAT IS[12:0], Ecode[21:16], EsubCode[30:22]; EENTRY VA[31:6]; TCFG En[0], Periodic[1], InitVal[31:2]; all other bits read 0.
REQ-012 SHALL allow software writes only to ESTAT.IS[1:0]; IS[9:2] SHALL equal hw_int_in registered each cycle; IS[12] SHALL equal ipi_int_in registered.
REQ-013 SHALL treat TVAL as read-only and TICLR reads as 0; a write with TICLR mask&value bit0 = 1 SHALL clear ESTAT.IS[11].
REQ-014 SHALL, on a TCFG write, load TVAL <= {new InitVal, 2'b00} next cycle.
REQ-015 SHALL otherwise, when TCFG.En = 1 and TVAL != 32'hFFFF_FFFF, decrement TVAL by 1 per cycle; at TVAL = 0 with Periodic = 1, reload {InitVal, 2'b00} instead.
REQ-016 SHALL set ESTAT.IS[11] in the cycle following TVAL = 0 with En = 1; one-shot mode SHALL stop at 32'hFFFF_FFFF.
REQ-017 SHALL drive has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
REQ-018 SHALL, when wb_exc != 0: PRMD.PPLV <= CRMD.PLV, PRMD.PIE <= CRMD.IE, CRMD.PLV <= 0, CRMD.IE <= 0, ERA <= wb_pc.
REQ-019 SHALL encode Ecode by priority int 0x00 > adef 0x08 > ine 0x0D > sys 0x0B > brk 0x0C > ale 0x09, EsubCode 0.
REQ-020 SHALL load BADV <= wb_pc on adef and BADV <= wb_fault_vaddr on ale; otherwise BADV is unchanged.
REQ-021 SHALL, on ertn_flush with wb_exc = 0: CRMD.PLV <= PRMD.PPLV, CRMD.IE <= PRMD.PIE.
REQ-022 SHALL give priority: exception > ertn > csr_we; a write in the same cycle as exception or ertn SHALL be dropped.
REQ-023 SHALL give timer reload from a TCFG write priority over decrement, and hardware IS[11] set priority over a TICLR clear in the same cycle.
REQ-024 SHALL present ex_entry and ertn_entry from current registers, zero latency, so a same-cycle redirect uses pre-update values.

Reset
REQ-025 SHALL on resetn = 0 at posedge set CRMD = 0x0000_0008 (PLV0, IE0, DA1).
REQ-026 SHALL on reset set PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TCFG = 0, TVAL = 32'hFFFF_FFFF, TID = TID_RESET.
REQ-027 SHALL abort timer countdown on reset mid-operation; has_int = 0 and ertn_entry = 0 out of reset.

Verification
REQ-028 SHALL cover: write CRMD mask 0x7 value 0x5 -> read CRMD = 0x0000_000D; write ECFG all-ones -> read 0x0000_1BFF.
REQ-029 SHALL cover: TCFG = 0x0000_0013 (InitVal 4, periodic, En) -> TVAL 16,15..0, IS[11] = 1, reload to 16; TICLR bit0 write -> IS[11] = 0.
REQ-030 SHALL cover: CRMD.PLV = 3, IE = 1, wb_exc sys, wb_pc 0x1C00_0100 -> ERA = 0x1C00_0100, Ecode 0x0B, PRMD = 0x7, CRMD = 0x8.
REQ-031 SHALL cover: ertn_flush after REQ-030 -> CRMD.PLV = 3, IE = 1; ertn_entry = 0x1C00_0100.
REQ-032 SHALL cover: ale with wb_fault_vaddr 0x8000_0003 plus same-cycle csr_we to SAVE0 -> BADV = 0x8000_0003, Ecode 0x09, SAVE0 unchanged.
REQ-033 SHALL cover: ECFG.LIE[2] = 1, CRMD.IE = 1, hw_int_in[0] high -> has_int = 1 one cycle later; resetn low -> has_int = 0.
